// File: rtl/regfile_mp_if.sv
// Bus between decode/execute/memory stages and the multi-port register file.
// The priv signal exists only when BANKED_SP_LR_EN is defined.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4,
    parameter int NREAD  = 2,
    parameter int NFLAGS = 4
);
    logic                    not_enable;
    logic                    wa_en;
    logic [SEL_W-1:0]        wa_sel;
    logic [DATA_W-1:0]       wa_data;
    logic                    wb_en;
    logic [SEL_W-1:0]        wb_sel;
    logic [DATA_W-1:0]       wb_data;
    logic                    issue_en;
    logic [SEL_W-1:0]        issue_sel;
    logic [NREAD*SEL_W-1:0]  rd_sel;
    logic [NREAD*DATA_W-1:0] rd_data;
    logic [NREAD-1:0]        rd_ready;
    logic [NFLAGS-1:0]       flags_in;
    logic [NFLAGS-1:0]       flags_mask;
    logic [NFLAGS-1:0]       flags_out;
    logic                    pc_inc;
    logic [DATA_W-1:0]       pc_out;
`ifdef BANKED_SP_LR_EN
    logic                    priv;
`endif

    modport master (
        output not_enable, wa_en, wa_sel, wa_data, wb_en, wb_sel, wb_data,
               issue_en, issue_sel, rd_sel, flags_in, flags_mask, pc_inc,
`ifdef BANKED_SP_LR_EN
               priv,
`endif
        input  rd_data, rd_ready, flags_out, pc_out
    );

    modport slave (
        input  not_enable, wa_en, wa_sel, wa_data, wb_en, wb_sel, wb_data,
               issue_en, issue_sel, rd_sel, flags_in, flags_mask, pc_inc,
`ifdef BANKED_SP_LR_EN
               priv,
`endif
        output rd_data, rd_ready, flags_out, pc_out
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, bypassed reads, load scoreboard,
// auto-incrementing PC and masked flags. Define BANKED_SP_LR_EN for banked r13/r14.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = 4,
    parameter int NREAD    = 2,
    parameter int NFLAGS   = 4,
    parameter int PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        not_reset,
    regfile_mp_if.slave bus
);
    localparam int PC_IDX = NUM_REGS - 1;
`ifdef BANKED_SP_LR_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 0;
`endif
    // Banked r13/r14 live past the architectural range so one index space covers all storage.
    localparam int NPHYS = NUM_REGS + NBANK;

    logic [DATA_W-1:0] regs_q [NPHYS];
    logic [DATA_W-1:0] regs_d [NPHYS];
    logic [NPHYS-1:0]  busy_q, busy_d;
    logic [NFLAGS-1:0] flags_q, flags_d;

    logic                    enable;
    logic                    bank_sel;
    int                      wa_p, wb_p, iss_p;
    int                      rd_p [NREAD];
    logic [NREAD*DATA_W-1:0] rd_data_c;
    logic [NREAD-1:0]        rd_ready_c;

    assign enable = ~bus.not_enable;
`ifdef BANKED_SP_LR_EN
    assign bank_sel = bus.priv;
`else
    assign bank_sel = 1'b0;
`endif

    // Physical storage index for a select, or -1 when it names no register.
    function automatic int to_phys(input logic [SEL_W-1:0] sel, input logic bank);
        int idx;
        idx = int'(sel);
        if (idx >= NUM_REGS) return -1;
        if (bank && NBANK > 0 && (idx == 13 || idx == 14)) return NUM_REGS + idx - 13;
        return idx;
    endfunction

    always_comb begin
        wa_p  = (enable && bus.wa_en)    ? to_phys(bus.wa_sel, bank_sel)    : -1;
        wb_p  = (enable && bus.wb_en)    ? to_phys(bus.wb_sel, bank_sel)    : -1;
        iss_p = (enable && bus.issue_en) ? to_phys(bus.issue_sel, bank_sel) : -1;
        for (int i = 0; i < NREAD; i++) begin
            rd_p[i] = to_phys(bus.rd_sel[i*SEL_W +: SEL_W], bank_sel);
        end
    end

    // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
    always_comb begin
        regs_d  = regs_q;
        busy_d  = busy_q;
        flags_d = flags_q;
        if (enable) begin
            if (bus.pc_inc) regs_d[PC_IDX] = regs_q[PC_IDX] + DATA_W'(PC_STEP);
            flags_d = (flags_q & ~bus.flags_mask) | (bus.flags_in & bus.flags_mask);
        end
        // Later assignments win: wb over wa over pc_inc, and issue over wb clear.
        for (int r = 0; r < NPHYS; r++) begin
            if (wa_p == r) regs_d[r] = bus.wa_data;
            if (wb_p == r) begin
                regs_d[r] = bus.wb_data;
                busy_d[r] = 1'b0;
            end
            if (iss_p == r) busy_d[r] = 1'b1;
        end
    end

    always_comb begin
        rd_data_c  = '0;
        rd_ready_c = '1;
        for (int i = 0; i < NREAD; i++) begin
            for (int r = 0; r < NPHYS; r++) begin
                if (rd_p[i] == r) begin
                    rd_data_c[i*DATA_W +: DATA_W] = regs_q[r];
                    rd_ready_c[i]                 = ~busy_q[r];
                end
            end
            if (rd_p[i] >= 0 && rd_p[i] == wa_p) rd_data_c[i*DATA_W +: DATA_W] = bus.wa_data;
            if (rd_p[i] >= 0 && rd_p[i] == wb_p) begin
                rd_data_c[i*DATA_W +: DATA_W] = bus.wb_data;
                rd_ready_c[i]                 = 1'b1;
            end
        end
        // Bypass must not leak write data while reset is held.
        if (!not_reset) begin
            rd_data_c  = '0;
            rd_ready_c = '1;
        end
    end

    assign bus.rd_data   = rd_data_c;
    assign bus.rd_ready  = rd_ready_c;
    assign bus.flags_out = flags_q;
    assign bus.pc_out    = regs_q[PC_IDX];

    // NOTE: the register array is reset because software may read any register straight after reset.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            for (int r = 0; r < NPHYS; r++) regs_q[r] <= '0;
            busy_q  <= '0;
            flags_q <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            flags_q <= flags_d;
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default build, BANKED_SP_LR_EN undefined).
module tb_regfile_mp;
    logic clock;
    logic not_reset;
    int   n_cmp = 0;
    int   n_err = 0;

    regfile_mp_if #(.DATA_W(32), .SEL_W(4), .NREAD(2), .NFLAGS(4)) bus ();

    regfile_mp #(
        .DATA_W(32), .NUM_REGS(16), .SEL_W(4), .NREAD(2), .NFLAGS(4), .PC_STEP(4)
    ) dut (
        .clock    (clock),
        .not_reset(not_reset),
        .bus      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.not_enable = 1'b0;
        bus.wa_en      = 1'b0;
        bus.wa_sel     = '0;
        bus.wa_data    = '0;
        bus.wb_en      = 1'b0;
        bus.wb_sel     = '0;
        bus.wb_data    = '0;
        bus.issue_en   = 1'b0;
        bus.issue_sel  = '0;
        bus.flags_in   = '0;
        bus.flags_mask = '0;
        bus.pc_inc     = 1'b0;
    endtask

    task automatic set_rd(input logic [3:0] s0, input logic [3:0] s1);
        bus.rd_sel = {s1, s0};
    endtask

    task automatic test_reset();
        idle();
        set_rd(4'd5, 4'd6);
        not_reset = 1'b0;
        bus.wa_en = 1'b1; bus.wa_sel = 4'd5; bus.wa_data = 32'hAAAA_5555;
        bus.pc_inc = 1'b1; bus.flags_mask = 4'hF; bus.flags_in = 4'hF;
        step();
        step();
        n_cmp++; if (bus.rd_data !== 64'h0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
        n_cmp++; if (bus.rd_ready !== 2'b11) begin n_err++; $display("FAIL reset_rd_ready: got %b want 11", bus.rd_ready); end
        n_cmp++; if (bus.pc_out !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", bus.pc_out); end
        n_cmp++; if (bus.flags_out !== 4'h0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", bus.flags_out); end
        idle();
        #2 not_reset = 1'b1;
        step();
    endtask

    task automatic test_alu_write();
        idle();
        set_rd(4'd5, 4'd0);
        bus.wa_en = 1'b1; bus.wa_sel = 4'd5; bus.wa_data = 32'h1234_5678;
        #1;
        n_cmp++; if (bus.rd_data[31:0] !== 32'h1234_5678) begin n_err++; $display("FAIL alu_bypass: got %h want 12345678", bus.rd_data[31:0]); end
        step();
        idle();
        #1;
        n_cmp++; if (bus.rd_data[31:0] !== 32'h1234_5678) begin n_err++; $display("FAIL alu_stored: got %h want 12345678", bus.rd_data[31:0]); end
        n_cmp++; if (bus.rd_ready[0] !== 1'b1) begin n_err++; $display("FAIL alu_ready: got %b want 1", bus.rd_ready[0]); end
        n_cmp++; if (bus.rd_data[63:32] !== 32'h0) begin n_err++; $display("FAIL r0_untouched: got %h want 0", bus.rd_data[63:32]); end
    endtask

    task automatic test_dual_write();
        idle();
        set_rd(4'd5, 4'd6);
        bus.wa_en = 1'b1; bus.wa_sel = 4'd6; bus.wa_data = 32'h1111;
        bus.wb_en = 1'b1; bus.wb_sel = 4'd6; bus.wb_data = 32'h2222;
        #1;
        n_cmp++; if (bus.rd_data[63:32] !== 32'h2222) begin n_err++; $display("FAIL dual_bypass: got %h want 2222", bus.rd_data[63:32]); end
        step();
        idle();
        #1;
        n_cmp++; if (bus.rd_data[63:32] !== 32'h2222) begin n_err++; $display("FAIL dual_stored: got %h want 2222", bus.rd_data[63:32]); end
    endtask

    task automatic test_scoreboard();
        idle();
        set_rd(4'd3, 4'd4);
        bus.issue_en = 1'b1; bus.issue_sel = 4'd3;
        #1;
        n_cmp++; if (bus.rd_ready[0] !== 1'b1) begin n_err++; $display("FAIL sb_ready_before_edge: got %b want 1", bus.rd_ready[0]); end
        step();
        idle();
        #1;
        n_cmp++; if (bus.rd_ready[0] !== 1'b0) begin n_err++; $display("FAIL sb_busy: got %b want 0", bus.rd_ready[0]); end
        bus.wa_en = 1'b1; bus.wa_sel = 4'd3; bus.wa_data = 32'h55;
        step();
        idle();
        #1;
        n_cmp++; if (bus.rd_ready[0] !== 1'b0) begin n_err++; $display("FAIL sb_wa_keeps_busy: got %b want 0", bus.rd_ready[0]); end
        n_cmp++; if (bus.rd_data[31:0] !== 32'h55) begin n_err++; $display("FAIL sb_wa_data: got %h want 55", bus.rd_data[31:0]); end
        bus.wb_en = 1'b1; bus.wb_sel = 4'd3; bus.wb_data = 32'hDEAD;
        #1;
        n_cmp++; if (bus.rd_ready[0] !== 1'b1) begin n_err++; $display("FAIL sb_wb_ready: got %b want 1", bus.rd_ready[0]); end
        n_cmp++; if (bus.rd_data[31:0] !== 32'hDEAD) begin n_err++; $display("FAIL sb_wb_bypass: got %h want dead", bus.rd_data[31:0]); end
        step();
        idle();
        #1;
        n_cmp++; if (bus.rd_ready[0] !== 1'b1) begin n_err++; $display("FAIL sb_cleared: got %b want 1", bus.rd_ready[0]); end
        n_cmp++; if (bus.rd_data[31:0] !== 32'hDEAD) begin n_err++; $display("FAIL sb_wb_stored: got %h want dead", bus.rd_data[31:0]); end
        // Issue and writeback on the same index: busy ends up set.
        bus.issue_en = 1'b1; bus.issue_sel = 4'd4;
        bus.wb_en = 1'b1; bus.wb_sel = 4'd4; bus.wb_data = 32'h44;
        step();
        idle();
        #1;
        n_cmp++; if (bus.rd_ready[1] !== 1'b0) begin n_err++; $display("FAIL sb_set_wins: got %b want 0", bus.rd_ready[1]); end
        bus.wb_en = 1'b1; bus.wb_sel = 4'd4; bus.wb_data = 32'h45;
        step();
        idle();
    endtask

    task automatic test_flags();
        idle();
        bus.flags_in = 4'b1100; bus.flags_mask = 4'b1111;
        step();
        n_cmp++; if (bus.flags_out !== 4'b1100) begin n_err++; $display("FAIL flags_full: got %b want 1100", bus.flags_out); end
        bus.flags_in = 4'b0011; bus.flags_mask = 4'b0001;
        step();
        idle();
        n_cmp++; if (bus.flags_out !== 4'b1101) begin n_err++; $display("FAIL flags_masked: got %b want 1101", bus.flags_out); end
    endtask

    task automatic test_pc();
        idle();
        set_rd(4'd15, 4'd0);
        bus.pc_inc = 1'b1;
        step(); step(); step();
        n_cmp++; if (bus.pc_out !== 32'd12) begin n_err++; $display("FAIL pc_inc3: got %h want c", bus.pc_out); end
        n_cmp++; if (bus.rd_data[31:0] !== 32'd12) begin n_err++; $display("FAIL pc_read_pre_inc: got %h want c", bus.rd_data[31:0]); end
        idle();
        bus.wa_en = 1'b1; bus.wa_sel = 4'd15; bus.wa_data = 32'hFFFF_FFFC;
        step();
        idle();
        n_cmp++; if (bus.pc_out !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL pc_load: got %h want fffffffc", bus.pc_out); end
        bus.pc_inc = 1'b1;
        step();
        n_cmp++; if (bus.pc_out !== 32'h0) begin n_err++; $display("FAIL pc_wrap: got %h want 0", bus.pc_out); end
        bus.wa_en = 1'b1; bus.wa_sel = 4'd15; bus.wa_data = 32'h100;
        step();
        idle();
        n_cmp++; if (bus.pc_out !== 32'h100) begin n_err++; $display("FAIL pc_write_over_inc: got %h want 100", bus.pc_out); end
    endtask

    task automatic test_enable();
        idle();
        set_rd(4'd5, 4'd7);
        bus.not_enable = 1'b1;
        bus.wa_en = 1'b1; bus.wa_sel = 4'd5; bus.wa_data = 32'hBEEF;
        bus.issue_en = 1'b1; bus.issue_sel = 4'd7;
        bus.pc_inc = 1'b1; bus.flags_in = 4'b0000; bus.flags_mask = 4'b1111;
        #1;
        n_cmp++; if (bus.rd_data[31:0] !== 32'h1234_5678) begin n_err++; $display("FAIL en_no_bypass: got %h want 12345678", bus.rd_data[31:0]); end
        step();
        n_cmp++; if (bus.rd_data[31:0] !== 32'h1234_5678) begin n_err++; $display("FAIL en_frozen_reg: got %h want 12345678", bus.rd_data[31:0]); end
        n_cmp++; if (bus.pc_out !== 32'h100) begin n_err++; $display("FAIL en_frozen_pc: got %h want 100", bus.pc_out); end
        n_cmp++; if (bus.flags_out !== 4'b1101) begin n_err++; $display("FAIL en_frozen_flags: got %b want 1101", bus.flags_out); end
        n_cmp++; if (bus.rd_ready[1] !== 1'b1) begin n_err++; $display("FAIL en_frozen_busy: got %b want 1", bus.rd_ready[1]); end
        idle();
        bus.wa_en = 1'b1; bus.wa_sel = 4'd5; bus.wa_data = 32'hBEEF;
        step();
        idle();
        n_cmp++; if (bus.rd_data[31:0] !== 32'hBEEF) begin n_err++; $display("FAIL en_released: got %h want beef", bus.rd_data[31:0]); end
    endtask

    task automatic test_async_reset();
        idle();
        set_rd(4'd5, 4'd6);
        bus.issue_en = 1'b1; bus.issue_sel = 4'd5;
        step();
        idle();
        #2;
        n_cmp++; if (bus.rd_ready[0] !== 1'b0) begin n_err++; $display("FAIL ar_pre_busy: got %b want 0", bus.rd_ready[0]); end
        not_reset = 1'b0;
        #1;
        n_cmp++; if (bus.rd_data !== 64'h0) begin n_err++; $display("FAIL ar_rd_data: got %h want 0", bus.rd_data); end
        n_cmp++; if (bus.rd_ready !== 2'b11) begin n_err++; $display("FAIL ar_rd_ready: got %b want 11", bus.rd_ready); end
        n_cmp++; if (bus.pc_out !== 32'h0) begin n_err++; $display("FAIL ar_pc: got %h want 0", bus.pc_out); end
        n_cmp++; if (bus.flags_out !== 4'h0) begin n_err++; $display("FAIL ar_flags: got %b want 0", bus.flags_out); end
        #1 not_reset = 1'b1;
        step();
        n_cmp++; if (bus.rd_data !== 64'h0) begin n_err++; $display("FAIL ar_after_release: got %h want 0", bus.rd_data); end
        n_cmp++; if (bus.rd_ready !== 2'b11) begin n_err++; $display("FAIL ar_busy_cleared: got %b want 11", bus.rd_ready); end
    endtask

    initial begin
        not_reset = 1'b0;
        idle();
        set_rd(4'd0, 4'd0);
        test_reset();
        test_alu_write();
        test_dual_write();
        test_scoreboard();
        test_flags();
        test_pc();
        test_enable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
